uart_host_master: RTL
=====================

# uart_host_master

Hardware initiator for the memory-mapped UART peripheral's register interface. It sits where the CPU's load/store port would otherwise connect, converting a byte-stream TX channel and a byte-stream RX channel (valid/ready) into register reads and writes. Transmission uses the send bit of the control register; reception polls the new-RX flag. This lets non-CPU datapaths (test pattern engines, DMA-like blocks) use the UART without firmware.

## Interface
- TIMEOUT_CYCLES, 1_000_000: maximum cycles spent in TX_WAIT before abort (used only with the timeout feature).
- clk_pi  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_data_i  in  8  byte to transmit.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  byte accepted this cycle.
- rx_data_o  out  8  received byte.
- rx_valid_o  out  1  rx_data_o is valid; held until accepted.
- rx_ready_i  in  1  consumer accepts rx_data_o.
- busy_o  out  1  FSM not in IDLE.
- err_o  out  1  sticky TX timeout flag; cleared only by rst.
- we_o  out  1  register write enable to the peripheral.
- addr_o  out  2  peripheral address; bit0 selects the register, bit1 selects the data half.
- wdata_o  out  32  write data to the peripheral.
- rdata_i  in  32  combinational read data from the peripheral, valid in the same cycle as addr_o.

## Operation
- Address map: 2'b00 selects CTRL. CTRL bit0 is SEND, set by host and cleared by the peripheral when the frame is done. CTRL bit1 is NEWRX, set by the peripheral and cleared by host write. 2'b01 selects TXDATA (write). 2'b11 selects RXDATA (read).
- Moore FSM. Bus outputs decode from state only, plus the latched TX byte.
- IDLE: addr_o=00, we_o=0. Evaluate rdata_i:
  - If rdata_i[1]=1 and rx_valid_o=0, go to RX_READ. RX has priority.
  - Else if tx_valid_i=1, go to TX_LOAD.
  - Else stay in IDLE.
- RX_READ: addr_o=11. Capture rdata_i[7:0] into rx_data_o and set rx_valid_o at the edge. Go to RX_CLR.
- RX_CLR: we_o=1, addr_o=00, wdata_o=0. SEND is known 0 here. Go to IDLE.
- TX_LOAD: we_o=1, addr_o=01, wdata_o={24'b0,tx_data_i}, tx_ready_o=1. The byte is latched internally. Go to TX_GO.
- TX_GO: we_o=1, addr_o=00, wdata_o=32'h1. Go to TX_WAIT.
- TX_WAIT: addr_o=00. If rdata_i[0]=0, go to IDLE. A timeout to TX_ABORT applies when configured.
- TX_ABORT: we_o=1, addr_o=00, wdata_o=0, set err_o. Go to IDLE.
- RX buffer holds one entry. rx_valid_o falls on the edge where rx_valid_o & rx_ready_i. While the buffer is full, NEWRX is not serviced; peripheral overrun is outside this block's responsibility.
- tx_ready_o is asserted only in TX_LOAD, so at most one byte is in flight.
- A CTRL write in RX_CLR and a peripheral NEWRX set in the same cycle is a peripheral-side race. The host does not retry.

## Timing
- Reset values: state IDLE, we_o=0, addr_o=00, wdata_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0, busy_o=0, err_o=0. Timeout counter = 0.
- TX: the handshake completes in the TX_LOAD cycle, at least 1 cycle after IDLE sees tx_valid_i. SEND is set 2 cycles after acceptance. The FSM returns to IDLE 1 cycle after SEND reads 0.
- RX: the poll sees NEWRX in cycle N. The byte is read in N+1, and rx_valid_o=1 from N+2. NEWRX is cleared by the write in N+2, visible N+3.
- The minimum IDLE-to-IDLE period is 4 cycles for TX (with a 1-cycle wait) and 3 cycles for RX.
- Reset mid-transaction returns the FSM to IDLE immediately. A latched TX byte and a buffered RX byte are discarded. No bus cleanup write is issued.
- tx_valid_i dropping while the FSM is outside IDLE/TX_LOAD has no effect. Dropping in IDLE is legal (no transfer).

## Configuration
- UART_HOST_TIMEOUT_EN defined: a 32-bit counter runs in TX_WAIT and resets on entry. When it reaches TIMEOUT_CYCLES-1 while SEND is still 1, the FSM goes to TX_ABORT.
- Not defined: TX_WAIT waits indefinitely, TX_ABORT is unreachable, err_o is tied 0, and no counter is built.

## Structure
- Package uart_host_pkg holds:
  - the state enum;
  - ADDR_CTRL=2'b00, ADDR_TXDATA=2'b01, ADDR_RXDATA=2'b11;
  - CTRL_SEND_BIT=0, CTRL_NEWRX_BIT=1.
- Sub-module uart_host_rxbuf: the one-entry valid/ready holding register (load, data, valid, ready).
- FSM, timeout counter and bus decode live in the top.

## Test plan
- Bench: the UART peripheral connected with tx looped to rx, plus a scoreboard.
- TX single byte: tx_data_i=8'hA5 with valid → one TXDATA write of 32'h000000A5, then a CTRL write of 32'h1. The FSM returns to IDLE after SEND clears. The loopback returns 8'hA5 on rx_data_o.
- RX backpressure: hold rx_ready_i=0 while bytes 8'h3C then 8'hC3 arrive → rx_data_o stays 8'h3C with rx_valid_o=1. No RXDATA read occurs while full; NEWRX remains set. Release → 8'hC3 is delivered next.
- Priority: NEWRX=1 and tx_valid_i=1 in the same IDLE cycle → the RX_READ/RX_CLR sequence precedes TX_LOAD. tx_ready_o stays low until TX_LOAD.
- Stream: 16 back-to-back bytes 8'h00..8'h0F → all are received in order. tx_ready_o pulses exactly 16 times with no duplicates.
- Timeout (macro on, TIMEOUT_CYCLES=100): the peripheral model never clears SEND → TX_ABORT is entered after 100 cycles in TX_WAIT. A CTRL write of 0 occurs, err_o=1 and stays high.
- Reset: assert rst during TX_WAIT → all outputs take reset values immediately. The next transmission works normally.

Source files
------------

// File: rtl/uart_host_pkg.sv
// Shared types and constants for the UART host master: FSM states and the
// peripheral register map.
package uart_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_READ,
    ST_RX_CLR,
    ST_TX_LOAD,
    ST_TX_GO,
    ST_TX_WAIT,
    ST_TX_ABORT
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_TXDATA = 2'b01;
  localparam logic [1:0] ADDR_RXDATA = 2'b11;

  localparam int CTRL_SEND_BIT  = 0;
  localparam int CTRL_NEWRX_BIT = 1;

endpackage

// File: rtl/uart_host_if.sv
// Byte-stream and register-bus signals of the UART host master.
// Handshakes: a transfer happens on a rising edge where valid & ready; valid
// and data stay stable until that edge, and ready never waits on nothing else.
interface uart_host_if;
  import uart_host_pkg::*;

  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        busy_o;
  logic        err_o;
  logic        we_o;
  logic [1:0]  addr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i;
  state_t      dbg_state;

  modport master (
    input  tx_data_i, tx_valid_i, rx_ready_i, rdata_i,
    output tx_ready_o, rx_data_o, rx_valid_o, busy_o, err_o,
           we_o, addr_o, wdata_o, dbg_state
  );

  modport slave (
    output tx_data_i, tx_valid_i, rx_ready_i, rdata_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, busy_o, err_o,
           we_o, addr_o, wdata_o, dbg_state
  );

endinterface

// File: rtl/uart_host_rxbuf.sv
// One-entry valid/ready holding register for received bytes.
module uart_host_rxbuf (
  input  logic       clk_pi,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid
);

  logic [7:0] r_data;
  logic       r_valid;

  // The host only loads while empty, so load never collides with a pop.
  always_ff @(posedge clk_pi or posedge rst) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/uart_host_master.sv
// Register-bus initiator that turns TX/RX byte streams into UART peripheral
// accesses. Optional TX_WAIT timeout: define UART_HOST_TIMEOUT_EN.
module uart_host_master
  import uart_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic         clk_pi,
  input logic         rst,
  uart_host_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_tx_byte;
  logic       w_send;
  logic       w_newrx;
  logic       w_timeout;
  logic       w_unused;

  assign w_send  = bus.rdata_i[CTRL_SEND_BIT];
  assign w_newrx = bus.rdata_i[CTRL_NEWRX_BIT];

`ifdef UART_HOST_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] r_to_cnt;
  logic        r_err;

  // Held at zero outside TX_WAIT, so every wait starts counting from 0.
  always_ff @(posedge clk_pi or posedge rst) begin
    if (rst)                         r_to_cnt <= 32'd0;
    else if (r_state != ST_TX_WAIT)  r_to_cnt <= 32'd0;
    else                             r_to_cnt <= r_to_cnt + 32'd1;
  end

  always_ff @(posedge clk_pi or posedge rst) begin
    if (rst)                         r_err <= 1'b0;
    else if (w_next == ST_TX_ABORT)  r_err <= 1'b1;
  end

  assign w_timeout  = (r_to_cnt == TO_LAST);
  assign bus.err_o  = r_err;
  assign w_unused   = ^bus.rdata_i[31:8];
`else
  assign w_timeout  = 1'b0;
  assign bus.err_o  = 1'b0;
  assign w_unused   = ^{bus.rdata_i[31:8], 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk_pi or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // TX byte is captured on the IDLE->TX_LOAD edge so bus outputs stay Moore.
  always_ff @(posedge clk_pi or posedge rst) begin
    if (rst)
      r_tx_byte <= 8'h00;
    else if (r_state == ST_IDLE && w_next == ST_TX_LOAD)
      r_tx_byte <= bus.tx_data_i;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_newrx && !bus.rx_valid_o) w_next = ST_RX_READ;
        else if (bus.tx_valid_i)        w_next = ST_TX_LOAD;
      end
      ST_RX_READ:  w_next = ST_RX_CLR;
      ST_RX_CLR:   w_next = ST_IDLE;
      ST_TX_LOAD:  w_next = ST_TX_GO;
      ST_TX_GO:    w_next = ST_TX_WAIT;
      ST_TX_WAIT: begin
        if (!w_send)        w_next = ST_IDLE;
        else if (w_timeout) w_next = ST_TX_ABORT;
      end
      ST_TX_ABORT: w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.we_o       = 1'b0;
    bus.addr_o     = ADDR_CTRL;
    bus.wdata_o    = 32'h0;
    bus.tx_ready_o = 1'b0;
    case (r_state)
      ST_RX_READ: bus.addr_o = ADDR_RXDATA;
      ST_RX_CLR:  bus.we_o   = 1'b1;
      ST_TX_LOAD: begin
        bus.we_o       = 1'b1;
        bus.addr_o     = ADDR_TXDATA;
        bus.wdata_o    = {24'h0, r_tx_byte};
        bus.tx_ready_o = 1'b1;
      end
      ST_TX_GO: begin
        bus.we_o    = 1'b1;
        bus.wdata_o = 32'h1 << CTRL_SEND_BIT;
      end
      ST_TX_ABORT: bus.we_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy_o    = (r_state != ST_IDLE);
  assign bus.dbg_state = r_state;

  uart_host_rxbuf u_rxbuf (
    .clk_pi  (clk_pi),
    .rst     (rst),
    .i_load  (r_state == ST_RX_READ),
    .i_data  (bus.rdata_i[7:0]),
    .i_ready (bus.rx_ready_i),
    .o_data  (bus.rx_data_o),
    .o_valid (bus.rx_valid_o)
  );

endmodule
